// File: rtl/ball_ctrl_pkg.sv
// Shared types and helpers for the ball motion controller.
package ball_ctrl_pkg;
    localparam int COORD_W = 10;
    localparam int CAND_W  = 11;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    typedef logic signed [CAND_W-1:0] cand_t;

    function automatic logic [COORD_W-1:0] max_coord(input int active, input int size);
        return COORD_W'(active - size);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchroniser followed by a stability counter.
// The clean output follows the input only after it has differed for DEBOUNCE_CYC cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic raw,
    output logic clean
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q, clean_q, clean_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        if (sync2_q != clean_q) begin
            if (cnt_q == TC) clean_d = sync2_q;
            else             cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean = clean_q;
endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position sequencer: debounced buttons move the ball once per frame_tick.
// Optional AUTO_BOUNCE_EN adds an auto-bounce mode toggled by pressing up+down.
//
// state    | meaning
// S_WAIT   | idle, waiting for frame_tick (buttons latched on the tick)
// S_CALC   | form signed candidate position from buttons or velocity
// S_COMMIT | clamp, write position, pulse pos_valid, flag wall contact
module ball_motion_ctrl
    import ball_ctrl_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 16,
    parameter int STEP         = 4,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               frame_tick,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               pos_valid,
    output logic               led1,
    output logic               led2,
    output logic               led3,
    output logic               led4,
    output logic               led5
);
    localparam logic [COORD_W-1:0] MAX_X = max_coord(H_ACTIVE, BALL_SIZE);
    localparam logic [COORD_W-1:0] MAX_Y = max_coord(V_ACTIVE, BALL_SIZE);
    localparam cand_t MAX_X_S = cand_t'(MAX_X);
    localparam cand_t MAX_Y_S = cand_t'(MAX_Y);
    localparam cand_t STEP_S  = cand_t'(STEP);

    logic [3:0] btn_db;  // {right, left, down, up}
    logic [3:0] raw_btn;
    assign raw_btn = {right, left, down, up};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .sys_clk(sys_clk), .sys_rst(sys_rst), .raw(raw_btn[i]), .clean(btn_db[i])
        );
    end

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    cand_t              nx_q, nx_d, ny_q, ny_d;
    logic               mvx_q, mvx_d, mvy_q, mvy_d;
    logic [3:0]         btn_q, btn_d;
    logic               pos_valid_q, pos_valid_d, led5_q, led5_d;
    logic [COORD_W-1:0] x_cl, y_cl;
    logic               hit_x, hit_y;
`ifdef AUTO_BOUNCE_EN
    mode_t mode_q, mode_d;
    cand_t dx_q, dx_d, dy_q, dy_d;
    logic  ud_q, ud_d;
`endif

    function automatic cand_t axis_step(input logic neg, input logic pos);
        if (neg && !pos) return -STEP_S;
        if (pos && !neg) return STEP_S;
        return '0;
    endfunction

    assign x_cl  = nx_q[CAND_W-1] ? '0 : (nx_q > MAX_X_S) ? MAX_X : nx_q[COORD_W-1:0];
    assign y_cl  = ny_q[CAND_W-1] ? '0 : (ny_q > MAX_Y_S) ? MAX_Y : ny_q[COORD_W-1:0];
    // A moving axis that ends on a wall counts as contact, clamped or not.
    assign hit_x = mvx_q && ((x_cl == '0) || (x_cl == MAX_X));
    assign hit_y = mvy_q && ((y_cl == '0) || (y_cl == MAX_Y));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        mvx_d       = mvx_q;
        mvy_d       = mvy_q;
        btn_d       = btn_q;
        pos_valid_d = 1'b0;
        led5_d      = led5_q;
`ifdef AUTO_BOUNCE_EN
        dx_d   = dx_q;
        dy_d   = dy_q;
        ud_d   = btn_db[0] & btn_db[1];
        mode_d = mode_q;
        if (ud_d && !ud_q) mode_d = (mode_q == MANUAL) ? AUTO : MANUAL;
`endif
        case (state_q)
            S_WAIT: begin
                if (frame_tick) begin
                    btn_d   = btn_db;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                nx_d  = cand_t'(x_q) + axis_step(btn_q[2], btn_q[3]);
                ny_d  = cand_t'(y_q) + axis_step(btn_q[0], btn_q[1]);
                mvx_d = btn_q[2] ^ btn_q[3];
                mvy_d = btn_q[0] ^ btn_q[1];
`ifdef AUTO_BOUNCE_EN
                if (mode_q == AUTO) begin
                    nx_d  = cand_t'(x_q) + dx_q;
                    ny_d  = cand_t'(y_q) + dy_q;
                    mvx_d = 1'b1;
                    mvy_d = 1'b1;
                end
`endif
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                x_d         = x_cl;
                y_d         = y_cl;
                pos_valid_d = 1'b1;
                if (hit_x || hit_y) led5_d = ~led5_q;
`ifdef AUTO_BOUNCE_EN
                if (mode_q == AUTO) begin
                    if (hit_x) dx_d = -dx_q;
                    if (hit_y) dy_d = -dy_q;
                end
`endif
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_WAIT;
            x_q         <= MAX_X >> 1;
            y_q         <= MAX_Y >> 1;
            nx_q        <= '0;
            ny_q        <= '0;
            mvx_q       <= 1'b0;
            mvy_q       <= 1'b0;
            btn_q       <= '0;
            pos_valid_q <= 1'b0;
            led5_q      <= 1'b0;
`ifdef AUTO_BOUNCE_EN
            mode_q <= MANUAL;
            dx_q   <= STEP_S;
            dy_q   <= STEP_S;
            ud_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            mvx_q       <= mvx_d;
            mvy_q       <= mvy_d;
            btn_q       <= btn_d;
            pos_valid_q <= pos_valid_d;
            led5_q      <= led5_d;
`ifdef AUTO_BOUNCE_EN
            mode_q <= mode_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            ud_q   <= ud_d;
`endif
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign pos_valid = pos_valid_q;
    assign led1      = btn_db[0];
    assign led2      = btn_db[1];
    assign led3      = btn_db[2];
    assign led4      = btn_db[3];
    assign led5      = led5_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed self-checking bench for ball_motion_ctrl (debounce shortened to 16 cycles).
module tb_ball_motion_ctrl;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic       pos_valid, led1, led2, led3, led4, led5;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    ball_motion_ctrl #(.DEBOUNCE_CYC(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_tick(frame_tick),
        .up(up), .down(down), .left(left), .right(right),
        .ball_x(ball_x), .ball_y(ball_y), .pos_valid(pos_valid),
        .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5)
    );

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        up = 0; down = 0; left = 0; right = 0; frame_tick = 0;
        sys_rst = 1;
        wait_cyc(3);
        sys_rst = 0;
        wait_cyc(1);
    endtask

    // One frame_tick pulse; pv[k] is pos_valid sampled k cycles after the tick edge.
    task automatic do_tick(output logic [3:0] pv);
        frame_tick = 1;
        @(posedge sys_clk); #1;
        frame_tick = 0;
        pv[0] = pos_valid;
        for (int k = 1; k < 4; k++) begin
            @(posedge sys_clk); #1;
            pv[k] = pos_valid;
        end
    endtask

    task automatic test_reset();
        logic [3:0] pv;
        sys_rst = 1;
        wait_cyc(3);
        total_cnt++;
        if (ball_x !== 10'd312 || ball_y !== 10'd232 || pos_valid !== 1'b0) begin
            $display("FAIL reset_pos: got x=%0d y=%0d pv=%b, want 312 232 0", ball_x, ball_y, pos_valid);
        end else pass_cnt++;
        total_cnt++;
        if ({led1, led2, led3, led4, led5} !== 5'b0)
            $display("FAIL reset_leds: got %b want 00000", {led1, led2, led3, led4, led5});
        else pass_cnt++;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            do_tick(pv);
            total_cnt++;
            if (pv !== 4'b0100 || ball_x !== 10'd312 || ball_y !== 10'd232)
                $display("FAIL idle_tick%0d: got pv=%b x=%0d y=%0d, want 0100 312 232", t, pv, ball_x, ball_y);
            else pass_cnt++;
        end
        total_cnt++;
        if ({led1, led2, led3, led4, led5} !== 5'b0)
            $display("FAIL idle_leds: got %b want 00000", {led1, led2, led3, led4, led5});
        else pass_cnt++;
    endtask

    task automatic test_right_move();
        logic [3:0] pv;
        logic [9:0] exp_x;
        do_reset();
        right = 1;
        wait_cyc(25);
        total_cnt++;
        if (led4 !== 1'b1) $display("FAIL right_led4: got %b want 1", led4);
        else pass_cnt++;
        exp_x = 10'd312;
        for (int t = 0; t < 3; t++) begin
            exp_x = exp_x + 10'd4;
            do_tick(pv);
            total_cnt++;
            if (pv !== 4'b0100 || ball_x !== exp_x || ball_y !== 10'd232)
                $display("FAIL right_tick%0d: got pv=%b x=%0d y=%0d, want 0100 %0d 232", t, pv, ball_x, ball_y, exp_x);
            else pass_cnt++;
        end
        right = 0;
        wait_cyc(25);
        total_cnt++;
        if (led4 !== 1'b0) $display("FAIL right_release_led4: got %b want 0", led4);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [3:0] pv;
        logic       seen;
        do_reset();
        seen = 0;
        right = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge sys_clk); #1;
            seen = seen | led4;
        end
        right = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge sys_clk); #1;
            seen = seen | led4;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL glitch_led4: got %b want 0", seen);
        else pass_cnt++;
        do_tick(pv);
        total_cnt++;
        if (ball_x !== 10'd312) $display("FAIL glitch_x: got %0d want 312", ball_x);
        else pass_cnt++;
    endtask

    task automatic test_left_wall();
        logic [3:0] pv;
        int         exp_x, contacts;
        do_reset();
        left = 1;
        wait_cyc(25);
        exp_x = 312;
        contacts = 0;
        for (int t = 1; t <= 80; t++) begin
            exp_x = exp_x - 4;
            if (exp_x <= 0) begin
                exp_x = 0;
                contacts++;
            end
            do_tick(pv);
            total_cnt++;
            if (ball_x !== 10'(exp_x) || ball_y !== 10'd232 || pv !== 4'b0100)
                $display("FAIL left_tick%0d_pos: got x=%0d y=%0d pv=%b, want %0d 232 0100", t, ball_x, ball_y, pv, exp_x);
            else pass_cnt++;
            total_cnt++;
            if (led5 !== contacts[0])
                $display("FAIL left_tick%0d_led5: got %b want %b", t, led5, contacts[0]);
            else pass_cnt++;
        end
        left = 0;
    endtask

    task automatic test_diagonal();
        logic [3:0] pv;
        do_reset();
        up = 1; right = 1;
        wait_cyc(25);
        do_tick(pv);
        total_cnt++;
        if (ball_x !== 10'd316 || ball_y !== 10'd228)
            $display("FAIL diag_upright: got x=%0d y=%0d want 316 228", ball_x, ball_y);
        else pass_cnt++;
        up = 0; left = 1;
        wait_cyc(25);
        do_tick(pv);
        total_cnt++;
        if (ball_x !== 10'd316 || ball_y !== 10'd228 || led5 !== 1'b0)
            $display("FAIL diag_lr_hold: got x=%0d y=%0d led5=%b want 316 228 0", ball_x, ball_y, led5);
        else pass_cnt++;
        left = 0; right = 0;
`ifndef AUTO_BOUNCE_EN
        up = 1; down = 1;
        wait_cyc(25);
        do_tick(pv);
        total_cnt++;
        if (ball_x !== 10'd316 || ball_y !== 10'd228)
            $display("FAIL diag_ud_hold: got x=%0d y=%0d want 316 228", ball_x, ball_y);
        else pass_cnt++;
        up = 0; down = 0;
`endif
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        frame_tick = 1;
        wait_cyc(2);
        frame_tick = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (pos_valid === 1'b1) pulses++;
            @(posedge sys_clk); #1;
        end
        total_cnt++;
        if (pulses != 1) $display("FAIL back_to_back_pulses: got %0d want 1", pulses);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] pv;
        int         pulses;
        do_reset();
        right = 1;
        wait_cyc(25);
        do_tick(pv);
        total_cnt++;
        if (ball_x !== 10'd316) $display("FAIL midrst_pre_x: got %0d want 316", ball_x);
        else pass_cnt++;
        frame_tick = 1;
        @(posedge sys_clk); #1;
        frame_tick = 0;
        sys_rst = 1;
        @(posedge sys_clk); #1;
        total_cnt++;
        if (ball_x !== 10'd312 || ball_y !== 10'd232 || pos_valid !== 1'b0)
            $display("FAIL midrst_vals: got x=%0d y=%0d pv=%b want 312 232 0", ball_x, ball_y, pos_valid);
        else pass_cnt++;
        sys_rst = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk); #1;
            if (pos_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses != 0 || ball_x !== 10'd312)
            $display("FAIL midrst_discard: got pulses=%0d x=%0d want 0 312", pulses, ball_x);
        else pass_cnt++;
        right = 0;
    endtask

`ifdef AUTO_BOUNCE_EN
    task automatic test_auto();
        logic [3:0] pv;
        int         ex, ey, edx, edy, nx, ny;
        do_reset();
        up = 1; down = 1;
        wait_cyc(25);
        up = 0; down = 0;
        wait_cyc(25);
        ex = 312; ey = 232; edx = 4; edy = 4;
        for (int t = 1; t <= 62; t++) begin
            nx = ex + edx;
            ny = ey + edy;
            if (nx <= 0)   begin nx = 0;   edx = -edx; end
            else if (nx >= 624) begin nx = 624; edx = -edx; end
            if (ny <= 0)   begin ny = 0;   edy = -edy; end
            else if (ny >= 464) begin ny = 464; edy = -edy; end
            ex = nx; ey = ny;
            do_tick(pv);
            total_cnt++;
            if (ball_x !== 10'(ex) || ball_y !== 10'(ey))
                $display("FAIL auto_tick%0d: got x=%0d y=%0d want %0d %0d", t, ball_x, ball_y, ex, ey);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_right_move();
        test_glitch();
        test_left_wall();
        test_diagonal();
        test_back_to_back();
        test_reset_mid();
`ifdef AUTO_BOUNCE_EN
        test_auto();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
